// File: rtl/oled_mmio_pkg.sv
// Shared constants and types for the OLED/LED MMIO controller.
package oled_mmio_pkg;

    localparam logic [7:0] CharBase = 8'h00;
    localparam logic [7:0] LedOff   = 8'h40;
    localparam logic [7:0] CtrlOff  = 8'h44;

    localparam int CHAR_DEPTH    = 64;
    localparam int CtrlStartBit  = 0;
    localparam int CtrlBusyBit   = 0;
    localparam int CtrlFillLsb   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SER,
        CLR
    } state_e;

endpackage

// File: rtl/oled_lane_serializer.sv
// Turns a latched byte-enable mask into one (lane, byte) per cycle, lowest lane first.
// load_i bypasses the latch so the first lane issues in the same cycle the word arrives.
module oled_lane_serializer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    output logic        lane_valid_o,
    output logic [1:0]  lane_idx_o,
    output logic [7:0]  lane_byte_o,
    output logic        done_o
);

    logic [3:0]  pend_q, pend_d, src_mask;
    logic [31:0] data_q, data_d, src_data;

    always_comb begin
        src_mask   = load_i ? be_i   : pend_q;
        src_data   = load_i ? data_i : data_q;
        lane_idx_o = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (src_mask[i]) lane_idx_o = 2'(i);
        end
        lane_valid_o = |src_mask;
        case (lane_idx_o)
            2'd0:    lane_byte_o = src_data[7:0];
            2'd1:    lane_byte_o = src_data[15:8];
            2'd2:    lane_byte_o = src_data[23:16];
            default: lane_byte_o = src_data[31:24];
        endcase
        pend_d = src_mask;
        if (lane_valid_o) pend_d[lane_idx_o] = 1'b0;
        data_d = src_data;
        done_o = (pend_q == 4'b0000);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 4'b0000;
            data_q <= 32'h0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/oled_mmio_ctrl.sv
// MMIO slave arbitrating the character-RAM write port between CPU byte writes and a clear engine.
// Define OLED_MMIO_FILL_REG_EN to make the clear fill character software-writable via CTRL[15:8].
module oled_mmio_ctrl
    import oled_mmio_pkg::*;
#(
    parameter logic [7:0] FillChar     = 8'h20,
    parameter bit         ClearOnReset = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    output logic        bus_gnt_o,
    input  logic        bus_we_i,
    input  logic [3:0]  bus_be_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_rvalid_o,
    output logic [31:0] bus_rdata_o,
    output logic        bus_err_o,
    output logic [7:0]  led_o,
    output logic        char_we_o,
    output logic [5:0]  char_addr_o,
    output logic [7:0]  char_wdata_o
);

    state_e      state_q, state_d;
    logic [6:0]  clr_cnt_q, clr_cnt_d;
    logic [3:0]  word_q, word_d;
    logic [7:0]  led_q, led_d;
    logic        char_we_q, char_we_d;
    logic [5:0]  char_addr_q, char_addr_d;
    logic [7:0]  char_wdata_q, char_wdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0] word_off, fill_val, fill_rd;
    logic       is_char, is_led, is_ctrl, stall, wr, ser_load;
    logic       lane_valid, ser_done;
    logic [1:0] lane_idx;
    logic [7:0] lane_byte;
    logic       unused_addr;

    assign word_off    = {bus_addr_i[7:2], 2'b00};
    assign unused_addr = ^{bus_addr_i[31:8], bus_addr_i[1:0]};
    assign is_char     = (word_off >= CharBase) && (word_off < LedOff);
    assign is_led      = (word_off == LedOff);
    assign is_ctrl     = (word_off == CtrlOff);
    assign stall       = (state_q != IDLE) && bus_we_i && (is_char || is_ctrl);
    assign bus_gnt_o   = bus_req_i && !stall;
    assign wr          = bus_gnt_o && bus_we_i;
    assign ser_load    = wr && is_char && (|bus_be_i) && (state_q == IDLE);

`ifdef OLED_MMIO_FILL_REG_EN
    logic [7:0] fill_q, fill_d;

    assign fill_d   = (wr && is_ctrl && bus_be_i[1]) ? bus_wdata_i[15:8] : fill_q;
    assign fill_val = fill_q;
    assign fill_rd  = fill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) fill_q <= FillChar;
        else       fill_q <= fill_d;
    end
`else
    assign fill_val = FillChar;
    assign fill_rd  = 8'h00;
`endif

    oled_lane_serializer u_ser (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (ser_load),
        .be_i         (bus_be_i),
        .data_i       (bus_wdata_i),
        .lane_valid_o (lane_valid),
        .lane_idx_o   (lane_idx),
        .lane_byte_o  (lane_byte),
        .done_o       (ser_done)
    );

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        word_d       = word_q;
        led_d        = led_q;
        char_we_d    = 1'b0;
        char_addr_d  = char_addr_q;
        char_wdata_d = char_wdata_q;
        rvalid_d     = bus_gnt_o;
        err_d        = 1'b0;
        rdata_d      = 32'h0;

        if (bus_gnt_o) begin
            if (!is_char && !is_led && !is_ctrl) begin
                err_d = 1'b1;
            end else if (!bus_we_i && is_led) begin
                rdata_d = {24'h0, led_q};
            end else if (!bus_we_i && is_ctrl) begin
                rdata_d[CtrlFillLsb +: 8] = fill_rd;
                rdata_d[CtrlBusyBit]      = (state_q != IDLE);
            end
        end

        if (wr && is_led && bus_be_i[0]) led_d = bus_wdata_i[7:0];

        // Char outputs are registered, so each pulse is decided one cycle before it appears.
        case (state_q)
            IDLE: begin
                if (ser_load) begin
                    state_d      = SER;
                    word_d       = bus_addr_i[5:2];
                    char_we_d    = lane_valid;
                    char_addr_d  = {bus_addr_i[5:2], lane_idx};
                    char_wdata_d = lane_byte;
                end else if (wr && is_ctrl && bus_be_i[0] && bus_wdata_i[CtrlStartBit]) begin
                    state_d   = CLR;
                    clr_cnt_d = 7'd0;
                end
            end
            SER: begin
                if (ser_done) begin
                    state_d = IDLE;
                end else begin
                    char_we_d    = lane_valid;
                    char_addr_d  = {word_q, lane_idx};
                    char_wdata_d = lane_byte;
                end
            end
            CLR: begin
                if (clr_cnt_q < 7'(CHAR_DEPTH)) begin
                    char_we_d    = 1'b1;
                    char_addr_d  = clr_cnt_q[5:0];
                    char_wdata_d = fill_val;
                    clr_cnt_d    = clr_cnt_q + 7'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ClearOnReset ? CLR : IDLE;
            clr_cnt_q    <= 7'd0;
            word_q       <= 4'd0;
            led_q        <= 8'h00;
            char_we_q    <= 1'b0;
            char_addr_q  <= 6'd0;
            char_wdata_q <= 8'h00;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            word_q       <= word_d;
            led_q        <= led_d;
            char_we_q    <= char_we_d;
            char_addr_q  <= char_addr_d;
            char_wdata_q <= char_wdata_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign led_o        = led_q;
    assign char_we_o    = char_we_q;
    assign char_addr_o  = char_addr_q;
    assign char_wdata_o = char_wdata_q;
    assign bus_rvalid_o = rvalid_q;
    assign bus_err_o    = err_q;
    assign bus_rdata_o  = rdata_q;

endmodule

// File: tb/tb_oled_mmio_ctrl.sv
// Directed self-checking bench for oled_mmio_ctrl; covers OLED_MMIO_FILL_REG_EN when defined.
module tb_oled_mmio_ctrl;

`ifdef OLED_MMIO_FILL_REG_EN
    localparam logic [7:0] ExpFillRd = 8'h20;
`else
    localparam logic [7:0] ExpFillRd = 8'h00;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_i = 1'b0;
    logic        bus_gnt_o;
    logic        bus_we_i = 1'b0;
    logic [3:0]  bus_be_i = 4'h0;
    logic [31:0] bus_addr_i = 32'h0;
    logic [31:0] bus_wdata_i = 32'h0;
    logic        bus_rvalid_o;
    logic [31:0] bus_rdata_o;
    logic        bus_err_o;
    logic [7:0]  led_o;
    logic        char_we_o;
    logic [5:0]  char_addr_o;
    logic [7:0]  char_wdata_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ev_addr[$];
    int ev_data[$];
    int ev_cyc[$];

    oled_mmio_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_req_i    (bus_req_i),
        .bus_gnt_o    (bus_gnt_o),
        .bus_we_i     (bus_we_i),
        .bus_be_i     (bus_be_i),
        .bus_addr_i   (bus_addr_i),
        .bus_wdata_i  (bus_wdata_i),
        .bus_rvalid_o (bus_rvalid_o),
        .bus_rdata_o  (bus_rdata_o),
        .bus_err_o    (bus_err_o),
        .led_o        (led_o),
        .char_we_o    (char_we_o),
        .char_addr_o  (char_addr_o),
        .char_wdata_o (char_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Log every character-RAM write with the cycle it was visible in.
    always @(negedge clk_i) begin
        if (char_we_o) begin
            ev_addr.push_back(int'(char_addr_o));
            ev_data.push_back(int'(char_wdata_o));
            ev_cyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clearLog();
        ev_addr.delete();
        ev_data.delete();
        ev_cyc.delete();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One bus transfer: waits (bounded) for grant, then samples the single-cycle response.
    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int gcyc, output int waits);
        waits = 0;
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = we; bus_be_i = be; bus_addr_i = addr; bus_wdata_i = wdata;
        #1;
        while (!bus_gnt_o && waits < 200) begin
            @(negedge clk_i);
            #1;
            waits++;
        end
        if (!bus_gnt_o) begin
            checkOutput("gnt_timeout", bus_gnt_o, 1);
            bus_req_i = 1'b0;
            rdata = 32'h0; err = 1'b0; gcyc = -1;
            return;
        end
        gcyc = cyc;
        @(posedge clk_i);
        #1;
        bus_req_i = 1'b0; bus_we_i = 1'b0; bus_be_i = 4'h0;
        @(negedge clk_i);
        checkOutput("rvalid", bus_rvalid_o, 1);
        rdata = bus_rdata_o;
        err = bus_err_o;
        @(posedge clk_i);
        #1;
        checkOutput("rvalid_one_cycle", bus_rvalid_o, 0);
    endtask

    task automatic checkClear(input int base, input logic [7:0] fill);
        checkOutput("clr_events", (ev_addr.size() >= base + 64), 1);
        if (ev_addr.size() >= base + 64) begin
            for (int i = 0; i < 64; i++) begin
                checkOutput("clr_addr", ev_addr[base + i], i);
                checkOutput("clr_data", ev_data[base + i], {24'h0, fill});
                checkOutput("clr_cycle", ev_cyc[base + i], ev_cyc[base] + i);
            end
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          gc, wt;

    initial begin
        // Reset values
        waitCycles(3);
        @(negedge clk_i);
        checkOutput("rst_char_we", char_we_o, 0);
        checkOutput("rst_char_addr", char_addr_o, 0);
        checkOutput("rst_char_wdata", char_wdata_o, 0);
        checkOutput("rst_led", led_o, 0);
        checkOutput("rst_rvalid", bus_rvalid_o, 0);
        checkOutput("rst_rdata", bus_rdata_o, 0);
        checkOutput("rst_err", bus_err_o, 0);
        clearLog();
        rst_i = 1'b0;

        // Auto clear after reset, CHAR write held off until the cycle after index 63
        applyStimulus(1'b1, 4'b0001, 32'h0000_0000, 32'h0000_0061, rd, er, gc, wt);
        checkOutput("char_err_in_clr", er, 0);
        waitCycles(3);
        checkClear(0, 8'h20);
        checkOutput("stall_events", ev_addr.size(), 65);
        if (ev_addr.size() == 65) begin
            checkOutput("stall_release", gc, ev_cyc[63] + 1);
            checkOutput("post_clr_addr", ev_addr[64], 0);
            checkOutput("post_clr_data", ev_data[64], 32'h61);
            checkOutput("post_clr_cycle", ev_cyc[64], gc + 1);
        end

        // Two-lane CHAR write
        clearLog();
        applyStimulus(1'b1, 4'b1010, 32'h0000_0008, 32'h4443_4241, rd, er, gc, wt);
        checkOutput("ser_err", er, 0);
        waitCycles(4);
        checkOutput("ser_events", ev_addr.size(), 2);
        if (ev_addr.size() == 2) begin
            checkOutput("ser0_addr", ev_addr[0], 9);
            checkOutput("ser0_data", ev_data[0], 32'h42);
            checkOutput("ser0_cycle", ev_cyc[0], gc + 1);
            checkOutput("ser1_addr", ev_addr[1], 11);
            checkOutput("ser1_data", ev_data[1], 32'h44);
            checkOutput("ser1_cycle", ev_cyc[1], gc + 2);
        end

        // Four-lane write at the top word, then an empty-mask write
        clearLog();
        applyStimulus(1'b1, 4'b1111, 32'h0000_003C, 32'h0403_0201, rd, er, gc, wt);
        applyStimulus(1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, rd, er, gc, wt);
        waitCycles(4);
        checkOutput("quad_events", ev_addr.size(), 4);
        if (ev_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("quad_addr", ev_addr[i], 60 + i);
                checkOutput("quad_data", ev_data[i], i + 1);
            end
        end

        // Software clear with LED write and CTRL read while it runs
        clearLog();
        applyStimulus(1'b1, 4'b0001, 32'h0000_0044, 32'h0000_0001, rd, er, gc, wt);
        applyStimulus(1'b1, 4'b0001, 32'h0000_0040, 32'h0000_005A, rd, er, gc, wt);
        checkOutput("led_no_stall", wt, 0);
        checkOutput("led_value", led_o, 32'h5A);
        applyStimulus(1'b0, 4'b1111, 32'h0000_0044, 32'h0, rd, er, gc, wt);
        checkOutput("ctrl_busy", rd, {16'h0, ExpFillRd, 8'h01});
        waitCycles(70);
        checkClear(0, 8'h20);
        checkOutput("clr2_events", ev_addr.size(), 64);
        applyStimulus(1'b0, 4'b1111, 32'h0000_0044, 32'h0, rd, er, gc, wt);
        checkOutput("ctrl_idle", rd, {16'h0, ExpFillRd, 8'h00});
        applyStimulus(1'b0, 4'b1111, 32'h0000_0040, 32'h0, rd, er, gc, wt);
        checkOutput("led_read", rd, 32'h5A);
        applyStimulus(1'b0, 4'b1111, 32'h0000_0080, 32'h0, rd, er, gc, wt);
        checkOutput("unmapped_err", er, 1);
        checkOutput("unmapped_rdata", rd, 0);
        applyStimulus(1'b0, 4'b1111, 32'h0000_0010, 32'h0, rd, er, gc, wt);
        checkOutput("char_read_err", er, 0);
        checkOutput("char_read_rdata", rd, 0);

        // Reset at clear index 30 with a read in flight
        applyStimulus(1'b1, 4'b0001, 32'h0000_0044, 32'h0000_0001, rd, er, gc, wt);
        wt = 0;
        @(negedge clk_i);
        while (!(char_we_o && char_addr_o == 6'd30) && wt < 100) begin
            @(negedge clk_i);
            wt++;
        end
        checkOutput("reach_idx30", char_addr_o, 30);
        rst_i = 1'b1;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 32'h0000_0040;
        @(posedge clk_i);
        #1;
        bus_req_i = 1'b0;
        checkOutput("rst_mid_char_we", char_we_o, 0);
        checkOutput("rst_mid_rvalid", bus_rvalid_o, 0);
        checkOutput("rst_mid_led", led_o, 0);
        clearLog();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("rst_drop_rvalid", bus_rvalid_o, 0);
        waitCycles(70);
        checkClear(0, 8'h20);

`ifdef OLED_MMIO_FILL_REG_EN
        clearLog();
        applyStimulus(1'b1, 4'b0011, 32'h0000_0044, 32'h0000_2A01, rd, er, gc, wt);
        waitCycles(70);
        checkClear(0, 8'h2A);
        applyStimulus(1'b0, 4'b1111, 32'h0000_0044, 32'h0, rd, er, gc, wt);
        checkOutput("fill_read", rd, 32'h0000_2A00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oled_mmio_ctrl.md
Name: oled_mmio_ctrl

Overview:
- MMIO slave on the Ibex data bus for the display/LED region. Shares one resource, the 64-byte character-RAM write port, between two requesters: CPU byte writes and a hardware clear engine.
- Accepts word-aligned bus requests and serializes the enabled byte lanes into single-byte character-RAM writes.
- Holds the LED register and a control/status register.
- An upstream address decoder drives bus_req_i only for this block's region; this block decodes bus_addr_i[7:0] only.

Parameters:
- FillChar, 8'h20: character written by the clear engine; also the reset value of the fill register.
- ClearOnReset, 1: 1 = clear engine starts automatically in the first cycle after reset deasserts.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- bus_req_i  in  1  request (region already decoded).
- bus_gnt_o  out  1  grant, combinational.
- bus_we_i  in  1  write enable.
- bus_be_i  in  4  byte enables.
- bus_addr_i  in  32  word-aligned address; only [7:2] used.
- bus_wdata_i  in  32  write data.
- bus_rvalid_o  out  1  response valid.
- bus_rdata_o  out  32  read data.
- bus_err_o  out  1  error, valid with rvalid.
- led_o  out  8  LED register.
- char_we_o  out  1  character-RAM write strobe.
- char_addr_o  out  6  character index.
- char_wdata_o  out  8  character code.

Behaviour:
- Reset: state=CLR if ClearOnReset, else IDLE.
  - led_o=0, char_we_o=0, char_addr_o=0, char_wdata_o=0.
  - bus_rvalid_o=0, bus_err_o=0, bus_rdata_o=0.
  - Clear counter=0; fill register=FillChar.
- Register map (offset = addr[7:0]):
  - 0x00-0x3C CHAR: write-only. Byte lane k of word offset w maps to char index 4*(w>>2)+k. Reads return 0, err=0.
  - 0x40 LED: RW. Only be[0] updates led_o=wdata[7:0]. Reads return {24'b0, led_o}.
  - 0x44 CTRL: write bit0=1 with be[0] starts a clear. Read returns bit0=busy, bits[15:8]=fill char (see Optional Feature), all other bits 0.
  - 0x48-0xFC: unmapped. Granted; rvalid with err=1 and rdata=0; no side effects.
- Grant rule: bus_gnt_o = bus_req_i & ~stall. stall=1 when state!=IDLE and the request is a CHAR write or a CTRL write. Reads and LED writes are never stalled.
- Response: bus_rvalid_o asserts exactly 1 cycle after each grant, for exactly 1 cycle. Write responses are posted and do not wait for serialization to finish. Back-to-back grants are allowed.
- FSM:
  - IDLE:
    - Granted CHAR write with be!=0: latch be and wdata, go to SER.
    - Granted CHAR write with be=0: no RAM write, stay IDLE.
    - Granted CTRL write with bit0=1: go to CLR, counter=0.
  - SER: one char_we_o pulse per enabled lane, ascending lane order, one per cycle. The first pulse occurs the cycle after the grant. The cycle after the last lane's pulse, return to IDLE. A 4-lane write occupies 4 cycles of SER.
  - CLR: char_we_o=1 every cycle, char_addr_o=counter, char_wdata_o=fill. Counter increments each cycle. After index 63 is written, go to IDLE. Duration is 64 cycles; no wrap.
- busy (CTRL bit0) = state!=IDLE, sampled in the grant cycle.
- char_we_o is deasserted in every cycle not listed above.
- Clear requested while in SER: the CTRL write is stalled until SER completes, so no lane write is ever dropped.
- rst_i mid-SER or mid-CLR: all pending lanes are discarded and any in-flight response is dropped (rvalid=0). The block then restarts from the reset state, including the clear from index 0 if ClearOnReset=1.

Optional Feature:
- Macro: OLED_MMIO_FILL_REG_EN.
- With the macro defined:
  - A CTRL write with be[1]=1 loads the fill register from wdata[15:8].
  - When the same write also sets bit0, the new value is used by that clear.
  - CTRL read bits[15:8] return the fill register.
- Without the macro: fill is the constant FillChar, CTRL read bits[15:8]=0, and be[1] is ignored.

Decomposition:
- Shared package oled_mmio_pkg holds:
  - offset constants CharBase=8'h00, LedOff=8'h40, CtrlOff=8'h44;
  - state enum {IDLE, SER, CLR};
  - CHAR_DEPTH=64 and CTRL bit positions.
- One sub-module: oled_lane_serializer. Input: latched 4-bit be and 32-bit data. Output: one (lane index, byte, valid) per cycle, plus a done flag. Implemented as a priority pick of the lowest set bit, cleared after each issue.

Test Plan:
- Reset, ClearOnReset=1 → char_we_o high for 64 consecutive cycles with addr 0..63 and data 0x20; a CHAR write issued during this window keeps gnt low until the cycle after addr 63.
- Idle; write 0x44434241 to 0x08 with be=4'b1010 → two pulses: (addr 9, 0x42), then (addr 11, 0x44); rvalid 1 cycle after gnt with err=0.
- Write 0x5A to 0x40 while CLR runs → granted immediately, led_o=0x5A next cycle, clear continues unbroken.
- Read 0x44 during clear → rdata bit0=1. Read 0x44 after clear → bit0=0. Read 0x80 → err=1, rdata=0.
- With OLED_MMIO_FILL_REG_EN: write 0x00002A01 to 0x44 with be=4'b0011 → 64 writes of 0x2A; CTRL read returns 0x00002A00 afterwards.
- Assert rst_i at clear index 30 → char_we_o=0 during the reset cycle; after release, the clear restarts at addr 0; no rvalid for the aborted response.
